universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
Parametrised full-duplex shift register, successor to the fixed 4-bit parallel-load/serial-out register. A parallel word is accepted over a valid/ready handshake and shifted out one bit per enabled cycle, MSB- or LSB-first, while serial input bits are captured into the vacated end. On the final shift of each frame the captured word is presented on a parallel output with a one-cycle valid pulse. Back-to-back frames stream with no bubble. The block sits between a word-oriented producer/consumer and a bit-serial link in the layered-bench environment.

Parameters:
WIDTH, 8, frame length in bits; legal range 2..32.
LSB_FIRST, 0, 0 = shift left with MSB out first; 1 = shift right with LSB out first.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-high
load_valid  input  1  parallel_data_in is valid this cycle
load_ready  output  1  block can accept a load this cycle
parallel_data_in  input  WIDTH  word to serialise
shift_en  input  1  advance one bit this cycle; ignored in IDLE
serial_data_in  input  1  bit shifted into the vacated end
serial_data_out  output  1  current output bit
serial_valid  output  1  serial_data_out carries frame data
parallel_data_out  output  WIDTH  last completed captured word
out_valid  output  1  one-cycle pulse: new parallel_data_out
busy  output  1  frame in progress

Behaviour:
- One clock; reset is asynchronous and active-high. All flops clear on reset assertion, with no dependence on clk.
- Reset values: state IDLE, shift reg 0, bit counter 0, parallel_data_out 0, out_valid 0. serial_data_out, serial_valid and busy are 0.
- load_ready is forced to 0 while reset is high. Loads presented during reset are dropped.
- Bit counter is $clog2(WIDTH) bits wide and counts 0..WIDTH-1.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready = 1.
  - On load_valid: shift reg <= parallel_data_in, counter <= 0, go to SHIFT.
  - shift_en is ignored.
- SHIFT:
  - busy = 1, serial_valid = 1.
  - serial_data_out = reg[WIDTH-1] when LSB_FIRST=0, reg[0] when LSB_FIRST=1. The first bit is visible the cycle after the load is accepted.
- Shift step, on a clk edge with shift_en=1 in SHIFT:
  - LSB_FIRST=0: reg <= {reg[WIDTH-2:0], serial_data_in}.
  - LSB_FIRST=1: reg <= {serial_data_in, reg[WIDTH-1:1]}.
  - counter increments.
- Stall: shift_en=0 in SHIFT holds reg, counter and serial_data_out unchanged, with no limit on stall length.
- Final shift (counter==WIDTH-1 and shift_en=1):
  - parallel_data_out <= the post-shift reg value, and out_valid = 1 for exactly the next cycle.
  - Bit order of the captured word: for LSB_FIRST=0 the first received bit lands at the MSB; for LSB_FIRST=1 it lands at the LSB.
  - Without a load: go to IDLE.
- Back-to-back streaming:
  - load_ready = IDLE | (SHIFT & shift_en & counter==WIDTH-1). This is combinational from shift_en, documented as such.
  - If a load is accepted on the final-shift cycle: state stays SHIFT, reg <= the new word, counter <= 0. parallel_data_out/out_valid still update from the completed frame.
  - serial_valid stays high with no gap.
- Loads in SHIFT other than the final-shift cycle see load_ready=0 and are not accepted. The producer must hold load_valid.
- Reset mid-frame: the frame is aborted, no out_valid is produced, and outputs return to reset values immediately.
- parallel_data_out holds its value between frames.

Test Plan:
- WIDTH=8, LSB_FIRST=0: load 0x96, shift_en held 1, serial_data_in fed 0,0,1,1,1,1,0,0 -> serial_data_out 1,0,0,1,0,1,1,0 on 8 consecutive cycles; parallel_data_out=0x3C with out_valid high 1 cycle; then IDLE with busy=0.
- LSB_FIRST=1: load 0x96, serial_data_in fed 1,0,1,0,0,1,0,1 -> serial_data_out 0,1,1,0,1,0,0,1; parallel_data_out=0xA5.
- Stall: LSB_FIRST=0, load 0xF0, drop shift_en for 3 cycles after bit 2 -> serial_data_out holds 1 through the stall; 8 bits total, out_valid after the 8th enabled shift only.
- Back-to-back: load 0x81 then 0x7E with load_valid held and shift_en held -> 16 contiguous bits 1000000101111110; serial_valid never drops; out_valid pulses twice, 8 cycles apart.
- Load during SHIFT before the final bit: load_valid with 0x55 at bit 3 of a 0xFF frame -> load_ready=0; frame output unchanged; 0x55 accepted on the final-shift cycle.
- Reset mid-frame: assert reset asynchronously, between clock edges, at bit 4 -> busy, serial_valid, out_valid and parallel_data_out are 0 before the next edge; no out_valid after release; the next load of 0x96 serialises correctly.

Source files
------------

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: full-duplex parallel<->serial shift register.
// Ports: clk, reset (async, active-high); load_valid/load_ready +
//   parallel_data_in (word in); shift_en, serial_data_in (bit in);
//   serial_data_out, serial_valid (bit out); parallel_data_out,
//   out_valid (captured word, 1-cycle pulse); busy (frame active).
module universal_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_data_in,
    input  logic             shift_en,
    input  logic             serial_data_in,
    output logic             serial_data_out,
    output logic             serial_valid,
    output logic [WIDTH-1:0] parallel_data_out,
    output logic             out_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pdo_q, pdo_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] shifted;
    logic             last_shift;
    logic             accept;

    always_comb begin
        if (LSB_FIRST) begin
            shifted = {serial_data_in, sreg_q[WIDTH-1:1]};
        end else begin
            shifted = {sreg_q[WIDTH-2:0], serial_data_in};
        end
    end

    // Final shift of a frame; also the only SHIFT cycle that can
    // take the next word, so load_ready depends combinationally on
    // shift_en here.
    assign last_shift = (state_q == SHIFT) && shift_en
                        && (cnt_q == LAST);
    assign load_ready = !reset
                        && ((state_q == IDLE) || last_shift);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        pdo_d   = pdo_q;
        ov_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = parallel_data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        pdo_d = shifted;
                        ov_d  = 1'b1;
                        cnt_d = '0;
                        if (accept) begin
                            sreg_d = parallel_data_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            pdo_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            pdo_q   <= pdo_d;
            ov_q    <= ov_d;
        end
    end

    assign busy              = (state_q == SHIFT);
    assign serial_valid      = busy;
    assign serial_data_out   = busy
        && (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);
    assign parallel_data_out = pdo_q;
    assign out_valid         = ov_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed bench for universal_shift_reg,
// one MSB-first and one LSB-first instance sharing most inputs.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       shift_en;
    logic       sdi0, sdi1;
    logic [7:0] pdi;

    logic       lr0, sdo0, sv0, ov0, busy0;
    logic [7:0] pdo0;
    logic       lr1, sdo1, sv1, ov1, busy1;
    logic [7:0] pdo1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  a, b, f;
    logic [15:0] s, fin;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(lr0),
        .parallel_data_in(pdi), .shift_en(shift_en),
        .serial_data_in(sdi0), .serial_data_out(sdo0),
        .serial_valid(sv0), .parallel_data_out(pdo0),
        .out_valid(ov0), .busy(busy0)
    );

    universal_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(lr1),
        .parallel_data_in(pdi), .shift_en(shift_en),
        .serial_data_in(sdi1), .serial_data_out(sdo1),
        .serial_valid(sv1), .parallel_data_out(pdo1),
        .out_valid(ov1), .busy(busy1)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b1;
        shift_en   = 1'b0;
        sdi0       = 1'b0;
        sdi1       = 1'b0;
        pdi        = 8'hAA;
        repeat (2) tick();
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_sv", 32'(sv0), 32'd0);
        check("rst_sdo", 32'(sdo0), 32'd0);
        check("rst_ov", 32'(ov0), 32'd0);
        check("rst_pdo", 32'(pdo0), 32'd0);
        check("rst_lr0", 32'(lr0), 32'd0);
        check("rst_lr1", 32'(lr1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        load_valid = 1'b0;
        reset      = 1'b0;
        #1;
        check("idle_lr", 32'(lr0), 32'd1);

        // basic frame, both bit orders
        a = 8'h96;
        f = 8'h3C;
        b = 8'hA5;
        pdi = a;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        shift_en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sdi0 = f[7-i];
            sdi1 = b[i];
            check("t1_sdo0", 32'(sdo0), 32'(a[7-i]));
            check("t1_sdo1", 32'(sdo1), 32'(a[i]));
            check("t1_sv", 32'(sv0), 32'd1);
            check("t1_ov", 32'(ov0), 32'd0);
            tick();
        end
        check("t1_ov0", 32'(ov0), 32'd1);
        check("t1_pdo0", 32'(pdo0), 32'h3C);
        check("t1_ov1", 32'(ov1), 32'd1);
        check("t1_pdo1", 32'(pdo1), 32'hA5);
        check("t1_busy", 32'(busy0), 32'd0);
        tick();
        check("t1_ovlo", 32'(ov0), 32'd0);
        check("t1_hold", 32'(pdo0), 32'h3C);
        check("t1_idle", 32'(busy0), 32'd0);

        // stall after bit 2
        a = 8'hF0;
        pdi = a;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        sdi0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                shift_en = 1'b0;
                repeat (3) begin
                    check("st_sdo", 32'(sdo0), 32'd1);
                    check("st_ov", 32'(ov0), 32'd0);
                    check("st_busy", 32'(busy0), 32'd1);
                    tick();
                end
                shift_en = 1'b1;
            end
            check("st_bit", 32'(sdo0), 32'(a[7-k]));
            check("st_ov2", 32'(ov0), 32'd0);
            tick();
        end
        check("st_ovend", 32'(ov0), 32'd1);
        check("st_pdo", 32'(pdo0), 32'hFF);

        // back-to-back frames
        s   = 16'h817E;
        fin = 16'h3CA5;
        pdi = 8'h81;
        load_valid = 1'b1;
        tick();
        pdi = 8'h7E;
        for (int j = 0; j < 16; j++) begin
            sdi0 = fin[15-j];
            check("bb_sdo", 32'(sdo0), 32'(s[15-j]));
            check("bb_sv", 32'(sv0), 32'd1);
            check("bb_ov", 32'(ov0), 32'(j == 8));
            if (j == 8)
                check("bb_pdo1", 32'(pdo0), 32'h3C);
            if (j < 8)
                check("bb_lr", 32'(lr0), 32'(j == 7));
            tick();
            if (j == 7)
                load_valid = 1'b0;
        end
        check("bb_ov2", 32'(ov0), 32'd1);
        check("bb_pdo2", 32'(pdo0), 32'hA5);
        check("bb_busy", 32'(busy0), 32'd0);

        // load attempt mid-frame
        pdi = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        sdi0 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j == 3) begin
                load_valid = 1'b1;
                pdi = 8'h55;
            end
            if (j >= 3)
                check("ml_lr", 32'(lr0), 32'(j == 7));
            check("ml_sdo", 32'(sdo0), 32'd1);
            tick();
        end
        load_valid = 1'b0;
        check("ml_ov", 32'(ov0), 32'd1);
        check("ml_pdo", 32'(pdo0), 32'h00);
        check("ml_busy", 32'(busy0), 32'd1);
        a = 8'h55;
        sdi0 = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("ml_bit", 32'(sdo0), 32'(a[7-j]));
            tick();
        end
        check("ml_ov2", 32'(ov0), 32'd1);
        check("ml_pdo2", 32'(pdo0), 32'hFF);

        // async reset mid-frame
        pdi = 8'h96;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (4) tick();
        check("mr_busy_pre", 32'(busy0), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_busy", 32'(busy0), 32'd0);
        check("mr_sv", 32'(sv0), 32'd0);
        check("mr_ov", 32'(ov0), 32'd0);
        check("mr_pdo", 32'(pdo0), 32'h00);
        check("mr_sdo", 32'(sdo0), 32'd0);
        check("mr_lr", 32'(lr0), 32'd0);
        check("mr_busy1", 32'(busy1), 32'd0);
        load_valid = 1'b1;
        repeat (2) tick();
        #2;
        reset = 1'b0;
        load_valid = 1'b0;
        tick();
        check("mr_drop", 32'(busy0), 32'd0);
        repeat (9) begin
            check("mr_noov", 32'(ov0), 32'd0);
            tick();
        end
        a = 8'h96;
        f = 8'h3C;
        pdi = a;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sdi0 = f[7-i];
            check("mr_bit", 32'(sdo0), 32'(a[7-i]));
            tick();
        end
        check("mr_ov2", 32'(ov0), 32'd1);
        check("mr_pdo2", 32'(pdo0), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
